// File: rtl/modulation_freq_controller.sv
// Multi-channel ring-modulation frequency controller: debounced up/down keys step a
// per-channel note by a ratio, and a shared sequential divider turns it into FREQ_NUM/note.
module modulation_freq_controller #(
    parameter int NUM_CH          = 2,
    parameter int CH_W            = 1,
    parameter int W               = 32,
    parameter int FREQ_NUM        = 1562500,
    parameter int NOTE_INIT       = 440,
    parameter int NOTE_MIN        = 80,
    parameter int NOTE_MAX        = 2000,
    parameter int RATIO_NUM       = 1059,
    parameter int RATIO_DEN       = 1000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  key_up_n,
    input  logic                  key_down_n,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic                  edit_en,
    input  logic [NUM_CH-1:0]     enable_sw,
    output logic [NUM_CH*W-1:0]   freq_out,
    output logic [W-1:0]          note_out,
    output logic                  freq_valid,
    output logic                  busy,
    output logic [NUM_CH-1:0]     disabled
);

    localparam int DCW = $clog2(W);
    localparam logic [W-1:0]    NOTE_INIT_W = W'(NOTE_INIT);
    localparam logic [W-1:0]    NOTE_MIN_W  = W'(NOTE_MIN);
    localparam logic [W-1:0]    NOTE_MAX_W  = W'(NOTE_MAX);
    localparam logic [W-1:0]    RATIO_NUM_W = W'(RATIO_NUM);
    localparam logic [W-1:0]    RATIO_DEN_W = W'(RATIO_DEN);
    localparam logic [W-1:0]    FREQ_NUM_W  = W'(FREQ_NUM);
    localparam logic [W-1:0]    FREQ_INIT_W = W'(FREQ_NUM / NOTE_INIT);
    localparam logic [31:0]     DB_LAST     = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]     REP_DLY     = 32'(REPEAT_DELAY);
    localparam logic [31:0]     REP_PER     = 32'(REPEAT_PERIOD);
    localparam logic [DCW-1:0]  DIV_LAST    = DCW'(W - 1);
    localparam logic [CH_W:0]   NUM_CH_C    = (CH_W + 1)'(NUM_CH);

    typedef enum logic [2:0] {IDLE, MUL, DIV_NOTE, DIV_FREQ, WRITE} state_t;

    state_t state, state_nxt;

    // Key index 0 is step-up, 1 is step-down; all key state is kept in pressed polarity.
    logic [1:0]  raw_pressed;
    logic [1:0]  sync1, sync2, key_db, key_db_q;
    logic [31:0] db_cnt  [2];
    logic [31:0] rep_cnt [2];
    logic [1:0]  rep_on;
    logic [1:0]  rep_fire;
    logic [1:0]  evt;

    logic [W-1:0]      notes [NUM_CH];
    logic [CH_W-1:0]   ch_lat;
    logic              dir_up;
    logic [W-1:0]      note_lat;
    logic [W-1:0]      rem, quo, dvsr;
    logic [DCW-1:0]    div_cnt;
    logic              ovf;

    logic              sel_ok, acc_up, acc_dn, accept, div_last;
    logic [2*W-1:0]    prod;
    logic [W-1:0]      mul_ratio, note_dvsr;
    logic [W:0]        rem_sh;
    logic [W-1:0]      rem_nxt, quo_nxt, note_q, note_clamped;

    assign raw_pressed = {~key_down_n, ~key_up_n};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1    <= '0;
            sync2    <= '0;
            key_db   <= '0;
            key_db_q <= '0;
            rep_on   <= '0;
            for (int k = 0; k < 2; k++) begin
                db_cnt[k]  <= '0;
                rep_cnt[k] <= '0;
            end
        end else begin
            sync1    <= raw_pressed;
            sync2    <= sync1;
            key_db_q <= key_db;
            for (int k = 0; k < 2; k++) begin
                if (sync2[k] != key_db[k]) begin
                    if (db_cnt[k] == DB_LAST) begin
                        key_db[k] <= sync2[k];
                        db_cnt[k] <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + 32'd1;
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
                // rep_cnt holds the number of cycles since the press or the last repeat
                if (!key_db[k]) begin
                    rep_cnt[k] <= '0;
                    rep_on[k]  <= 1'b0;
                end else if (rep_fire[k]) begin
                    rep_cnt[k] <= 32'd1;
                    rep_on[k]  <= 1'b1;
                end else begin
                    rep_cnt[k] <= rep_cnt[k] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        rep_fire = '0;
        for (int k = 0; k < 2; k++) begin
            if (REPEAT_DELAY != 0 && key_db[k])
                rep_fire[k] = rep_on[k] ? (rep_cnt[k] == REP_PER) : (rep_cnt[k] == REP_DLY);
        end
    end

    assign evt = (key_db & ~key_db_q) | rep_fire;

    always_comb begin
        note_out = '0;
        if (sel_ok)
            note_out = notes[ch_sel];
    end

    assign sel_ok = {1'b0, ch_sel} < NUM_CH_C;
    assign acc_up = (state == IDLE) && edit_en && sel_ok && evt[0] && !evt[1] && (note_out < NOTE_MAX_W);
    assign acc_dn = (state == IDLE) && edit_en && sel_ok && evt[1] && !evt[0] && (note_out > NOTE_MIN_W);
    assign accept = acc_up || acc_dn;

    assign mul_ratio = dir_up ? RATIO_NUM_W : RATIO_DEN_W;
    assign note_dvsr = dir_up ? RATIO_DEN_W : RATIO_NUM_W;
    assign prod      = (2*W)'(note_lat) * (2*W)'(mul_ratio);
    assign div_last  = (div_cnt == DIV_LAST);

    // One restoring-division step; the dividend's low half shifts out through quo.
    always_comb begin
        rem_sh  = {rem, quo[W-1]};
        rem_nxt = rem_sh[W-1:0];
        quo_nxt = {quo[W-2:0], 1'b0};
        if (rem_sh >= {1'b0, dvsr}) begin
            rem_nxt    = W'(rem_sh - {1'b0, dvsr});
            quo_nxt[0] = 1'b1;
        end
        note_q       = ovf ? NOTE_MAX_W : quo_nxt;
        note_clamped = note_q;
        if (note_q < NOTE_MIN_W)
            note_clamped = NOTE_MIN_W;
        else if (note_q > NOTE_MAX_W)
            note_clamped = NOTE_MAX_W;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = (state != IDLE);
        freq_valid = (state == WRITE);
        case (state)
            IDLE:     if (accept) state_nxt = MUL;
            MUL:      state_nxt = DIV_NOTE;
            DIV_NOTE: if (div_last) state_nxt = DIV_FREQ;
            DIV_FREQ: if (div_last) state_nxt = WRITE;
            WRITE:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // The new note and divisor land together on entry to WRITE, so they are valid with freq_valid.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ch_lat   <= '0;
            dir_up   <= 1'b0;
            note_lat <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            div_cnt  <= '0;
            ovf      <= 1'b0;
            freq_out <= {NUM_CH{FREQ_INIT_W}};
            for (int i = 0; i < NUM_CH; i++)
                notes[i] <= NOTE_INIT_W;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ch_lat   <= ch_sel;
                        dir_up   <= acc_up;
                        note_lat <= note_out;
                    end
                end
                MUL: begin
                    rem     <= prod[2*W-1:W];
                    quo     <= prod[W-1:0];
                    dvsr    <= note_dvsr;
                    ovf     <= (prod[2*W-1:W] >= note_dvsr);
                    div_cnt <= '0;
                end
                DIV_NOTE: begin
                    if (div_last) begin
                        rem     <= '0;
                        quo     <= FREQ_NUM_W;
                        dvsr    <= note_clamped;
                        div_cnt <= '0;
                    end else begin
                        rem     <= rem_nxt;
                        quo     <= quo_nxt;
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DIV_FREQ: begin
                    if (div_last) begin
                        notes[ch_lat]          <= dvsr;
                        freq_out[ch_lat*W +: W] <= quo_nxt;
                    end else begin
                        rem     <= rem_nxt;
                        quo     <= quo_nxt;
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            disabled <= '1;
        else
            disabled <= ~enable_sw;
    end

endmodule
